sram_port_master: RTL and testbench

- Bus initiator for the team's single-port synchronous RAM: the other end of the cs/wr/oe/addr/shared-data interface.
- Converts a valid/ready request stream (read or write) into correctly sequenced RAM bus cycles.
- Owns the tristate data bus direction and returns read data on a valid/ready response channel.
- Sits between any client (CPU stub, DMA, test driver) and one RAM instance.

---
 rtl/sram_port_pkg.sv | 17 +
 rtl/sram_port_master.sv | 126 ++++++++++++
 tb/tb_sram_port_master.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_pkg.sv
// Shared definitions for the single-port RAM bus initiator.
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry
//   state_e                 : bus-cycle sequencer states
package sram_port_pkg;

   localparam int unsigned ADDR_W_DEF = 4;
   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      RD_ADDR = 3'd2,
      RD_DATA = 3'd3,
      RSP     = 3'd4
   } state_e;

endpackage : sram_port_pkg

// File: rtl/sram_port_master.sv
// Bus initiator for the single-port synchronous RAM. Turns a valid/ready
// request stream into sequenced cs/wr/oe cycles, owns the shared data bus
// direction and returns read data on a valid/ready response channel.
//   clock, rst_n                     : clock (rising edge), async active-low reset
//   req_valid/req_ready/req_wr/
//   req_addr/req_wdata               : request channel
//   wr_done                          : one-cycle pulse after the RAM write edge
//   rsp_valid/rsp_ready/rsp_rdata    : read response channel
//   mem_addr/mem_data/mem_cs/
//   mem_wr/mem_oe                    : RAM bus (all outputs registered)
module sram_port_master
   import sram_port_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
   parameter int unsigned DATA_WIDTH = DATA_W_DEF
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  wr_done,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   inout  wire  [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_cs,
   output logic                  mem_wr,
   output logic                  mem_oe
);

   state_e                  state_q,   state_d;
   logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
   logic                    ready_q,   ready_d;
   logic                    wr_done_q, wr_done_d;
   logic                    rsp_vld_q, rsp_vld_d;
   logic                    cs_q,      cs_d;
   logic                    wr_q,      wr_d;
   logic                    oe_q,      oe_d;
   logic                    drive_q,   drive_d;

   // Next state, payload latches, and bus controls decoded from the next
   // state so every control flop lines up with the state it belongs to.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid && ready_q) begin
               addr_d = req_addr;
               if (req_wr) begin
                  wdata_d = req_wdata;
                  state_d = WRITE;
               end else begin
                  state_d = RD_ADDR;
               end
            end
         end
         WRITE:   state_d = IDLE;
         RD_ADDR: state_d = RD_DATA;
         RD_DATA: begin
            rdata_d = mem_data;
            state_d = RSP;
         end
         RSP:     if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      cs_d      = (state_d == WRITE) || (state_d == RD_ADDR) || (state_d == RD_DATA);
      wr_d      = (state_d == WRITE);
      oe_d      = (state_d == RD_DATA);
      // Only WRITE drives the bus; it is never entered straight from RD_DATA.
      drive_d   = (state_d == WRITE);
      ready_d   = (state_d == IDLE);
      wr_done_d = (state_q == WRITE);
      rsp_vld_d = (state_d == RSP);
   end

   // State and registered outputs.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         wr_done_q <= 1'b0;
         rsp_vld_q <= 1'b0;
         cs_q      <= 1'b0;
         wr_q      <= 1'b0;
         oe_q      <= 1'b0;
         drive_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         ready_q   <= ready_d;
         wr_done_q <= wr_done_d;
         rsp_vld_q <= rsp_vld_d;
         cs_q      <= cs_d;
         wr_q      <= wr_d;
         oe_q      <= oe_d;
         drive_q   <= drive_d;
      end
   end

   assign mem_data  = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
   assign mem_addr  = addr_q;
   assign mem_cs    = cs_q;
   assign mem_wr    = wr_q;
   assign mem_oe    = oe_q;
   assign req_ready = ready_q;
   assign wr_done   = wr_done_q;
   assign rsp_valid = rsp_vld_q;
   assign rsp_rdata = rdata_q;

endmodule : sram_port_master

// File: tb/tb_sram_port_master.sv
// Bench for sram_port_master: drives the request channel, models the
// single-port RAM on the other side, and compares against an array model.
module tb_sram_port_master;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 16;

   logic          clock;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          wr_done;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] mem_addr;
   wire  [DW-1:0] mem_data;
   logic          mem_cs;
   logic          mem_wr;
   logic          mem_oe;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [DW-1:0] ref_mem [16];

   int            wr_done_cyc_q [$];
   int            rsp_start_q   [$];
   logic [DW-1:0] rsp_data_q    [$];
   int            contention = 0;
   logic          rsp_valid_prev = 1'b0;

   sram_port_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .wr_done   (wr_done),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_cs    (mem_cs),
      .mem_wr    (mem_wr),
      .mem_oe    (mem_oe)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Single-port synchronous RAM: address latched on a cs read cycle,
   // presented on the bus while oe is asserted.
   logic [DW-1:0] ram [16];
   logic [DW-1:0] ram_rd_q;
   wire           ram_drive = mem_cs & mem_oe & ~mem_wr;
   assign mem_data = ram_drive ? ram_rd_q : {DW{1'bz}};

   always @(posedge clock) begin
      if (mem_cs && mem_wr) ram[mem_addr] <= mem_data;
      else if (mem_cs)      ram_rd_q      <= ram[mem_addr];
   end

   // Event recorder sampled mid-cycle.
   always @(negedge clock) begin
      if (rst_n) begin
         if (wr_done)                      wr_done_cyc_q.push_back(cyc);
         if (rsp_valid && !rsp_valid_prev) rsp_start_q.push_back(cyc);
         if (rsp_valid && rsp_ready)       rsp_data_q.push_back(rsp_rdata);
      end
      if (dut.drive_q && (mem_oe || ram_drive)) contention = contention + 1;
      rsp_valid_prev = rsp_valid;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Present a request and wait for its acceptance edge; returns the cycle
   // number of that edge. Caller is positioned just after a rising edge.
   task automatic send(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int acc);
      int n = 0;
      req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
      acc = -1;
      while (acc < 0 && n < 50) begin
         @(negedge clock);
         if (req_ready) begin
            @(posedge clock); #1;
            acc = cyc;
         end else begin
            n++;
         end
      end
      req_valid = 1'b0;
      total++;
      if (acc < 0) begin
         bad++;
         $display("FAIL send_accept: request wr=%0b addr=%0d not accepted within 50 cycles", wr, a);
      end else if (wr) begin
         ref_mem[a] = d;
      end
   endtask

   // Issue a read and collect its response; lat is edges from acceptance
   // to rsp_valid first seen high.
   task automatic do_read(input logic [AW-1:0] a, input bit rnd,
                          output logic [DW-1:0] d, output int lat, output int acc);
      int n = 0;
      bit got = 0;
      rsp_start_q.delete();
      rsp_data_q.delete();
      send(1'b0, a, '0, acc);
      while (!got && n < 60) begin
         if (rnd) rsp_ready = 1'($urandom_range(0, 1));
         @(negedge clock); #1;
         if (rsp_data_q.size() > 0) got = 1;
         @(posedge clock); #1;
         n++;
      end
      rsp_ready = 1'b1;
      total++;
      if (!got) begin
         bad++;
         $display("FAIL rsp_timeout: no response for read addr=%0d", a);
         d = 'x; lat = -1;
      end else begin
         d   = rsp_data_q.pop_front();
         lat = (rsp_start_q.size() > 0) ? rsp_start_q[0] - acc : -1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
      req_wdata = '0; rsp_ready = 1'b1;
      #1;
      total++;
      if ({mem_cs, mem_wr, mem_oe, req_ready, wr_done, rsp_valid, dut.drive_q} !== 7'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got cs/wr/oe/rdy/wd/rv/drv=%b expected 0000000",
                  {mem_cs, mem_wr, mem_oe, req_ready, wr_done, rsp_valid, dut.drive_q});
      end
      total++;
      if (mem_addr !== '0 || rsp_rdata !== '0) begin
         bad++;
         $display("FAIL reset_data: got mem_addr=%h rsp_rdata=%h expected 0 0", mem_addr, rsp_rdata);
      end
      repeat (3) @(negedge clock);
      rst_n = 1'b1;
      #1;
      total++;
      if (req_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready_first: got req_ready=%b expected 0", req_ready);
      end
      @(posedge clock); #1;
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready_idle: got req_ready=%b expected 1", req_ready);
      end
   endtask

   task automatic test_write_read();
      int acc, lat;
      logic [DW-1:0] d;
      wr_done_cyc_q.delete();
      send(1'b1, 4'd3, 16'hA5A5, acc);
      @(negedge clock); #1;
      total++;
      if ({mem_cs, mem_wr, mem_oe} !== 3'b110 || mem_addr !== 4'd3 || mem_data !== 16'hA5A5) begin
         bad++;
         $display("FAIL write_cycle: got cs/wr/oe=%b addr=%h data=%h expected 110 3 a5a5",
                  {mem_cs, mem_wr, mem_oe}, mem_addr, mem_data);
      end
      repeat (3) @(negedge clock); #1;
      total++;
      if (wr_done_cyc_q.size() != 1 || wr_done_cyc_q[0] != acc + 1) begin
         bad++;
         $display("FAIL wr_done_pulse: got %0d pulses first_at=%0d expected 1 at %0d",
                  wr_done_cyc_q.size(), (wr_done_cyc_q.size() > 0) ? wr_done_cyc_q[0] : -1, acc + 1);
      end
      @(posedge clock); #1;
      do_read(4'd3, 1'b0, d, lat, acc);
      // Valid appears two edges after acceptance, i.e. in the third cycle.
      total++;
      if (lat != 2) begin
         bad++;
         $display("FAIL read_latency: got %0d edges expected 2", lat);
      end
      total++;
      if (d !== 16'hA5A5) begin
         bad++;
         $display("FAIL read_data: got %h expected a5a5", d);
      end
   endtask

   task automatic test_back_to_back();
      int acc [16];
      int lat;
      logic [DW-1:0] d;
      wr_done_cyc_q.delete();
      for (int i = 0; i < 16; i++) send(1'b1, AW'(i), DW'(i) * 16'h1111, acc[i]);
      repeat (2) @(negedge clock); #1;
      total++;
      if (wr_done_cyc_q.size() != 16) begin
         bad++;
         $display("FAIL b2b_wr_done_count: got %0d expected 16", wr_done_cyc_q.size());
      end
      for (int i = 1; i < 16; i++) begin
         total++;
         if (acc[i] - acc[i-1] != 2) begin
            bad++;
            $display("FAIL b2b_write_cadence: write %0d got %0d cycles expected 2", i, acc[i] - acc[i-1]);
         end
      end
      @(posedge clock); #1;
      for (int i = 0; i < 16; i++) begin
         do_read(AW'(i), 1'b0, d, lat, acc[i]);
         total++;
         if (d !== DW'(i) * 16'h1111) begin
            bad++;
            $display("FAIL b2b_read_data: addr %0d got %h expected %h", i, d, DW'(i) * 16'h1111);
         end
         if (i > 0) begin
            total++;
            if (acc[i] - acc[i-1] != 4) begin
               bad++;
               $display("FAIL b2b_read_cadence: read %0d got %0d cycles expected 4", i, acc[i] - acc[i-1]);
            end
         end
      end
      total++;
      if (contention != 0) begin
         bad++;
         $display("FAIL b2b_contention: got %0d contention cycles expected 0", contention);
      end
   endtask

   task automatic test_backpressure();
      int acc;
      logic [DW-1:0] exp_d;
      exp_d = ref_mem[7];
      rsp_data_q.delete();
      rsp_ready = 1'b0;
      send(1'b0, 4'd7, '0, acc);
      repeat (3) @(negedge clock);
      for (int k = 0; k < 6; k++) begin
         total++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold: cycle %0d got valid=%b data=%h ready=%b expected 1 %h 0",
                     k, rsp_valid, rsp_rdata, req_ready, exp_d);
         end
         @(negedge clock);
      end
      @(posedge clock); #1;
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      @(negedge clock); #1;
      total++;
      if (rsp_valid !== 1'b0 || rsp_data_q.size() != 1) begin
         bad++;
         $display("FAIL bp_consume: got valid=%b responses=%0d expected 0 1", rsp_valid, rsp_data_q.size());
      end
      @(posedge clock); #1;
   endtask

   task automatic test_alternate();
      int acc, lat;
      logic [DW-1:0] d;
      logic [DW-1:0] exp_first;
      exp_first = ref_mem[2];
      do_read(4'd2, 1'b0, d, lat, acc);
      total++;
      if (d !== exp_first) begin
         bad++;
         $display("FAIL alt_read1: got %h expected %h", d, exp_first);
      end
      send(1'b1, 4'd2, 16'h1234, acc);
      do_read(4'd2, 1'b0, d, lat, acc);
      total++;
      if (d !== 16'h1234) begin
         bad++;
         $display("FAIL alt_read2: got %h expected 1234", d);
      end
      total++;
      if (contention != 0) begin
         bad++;
         $display("FAIL alt_contention: got %0d expected 0", contention);
      end
   endtask

   task automatic test_random();
      int acc, lat, nwr;
      logic [DW-1:0] d, dat;
      logic [AW-1:0] a;
      bit wr;
      nwr = 0;
      wr_done_cyc_q.delete();
      for (int k = 0; k < 40; k++) begin
         wr  = 1'($urandom_range(0, 1));
         a   = AW'($urandom_range(0, 15));
         dat = DW'($urandom);
         if (wr) begin
            send(1'b1, a, dat, acc);
            nwr++;
         end else begin
            do_read(a, 1'b1, d, lat, acc);
            total++;
            if (d !== ref_mem[a] || lat != 2) begin
               bad++;
               $display("FAIL rand_read: op %0d addr %0d got %h lat %0d expected %h lat 2",
                        k, a, d, lat, ref_mem[a]);
            end
         end
      end
      repeat (2) @(negedge clock); #1;
      total++;
      if (wr_done_cyc_q.size() != nwr) begin
         bad++;
         $display("FAIL rand_wr_done: got %0d pulses expected %0d", wr_done_cyc_q.size(), nwr);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_reset_mid();
      int acc, lat;
      logic [DW-1:0] d;
      send(1'b0, 4'd5, '0, acc);
      // Now in RD_ADDR; drop reset between edges.
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({mem_cs, mem_oe, rsp_valid, dut.drive_q, req_ready} !== 5'b0) begin
         bad++;
         $display("FAIL rstmid_async: got cs/oe/rv/drv/rdy=%b expected 00000",
                  {mem_cs, mem_oe, rsp_valid, dut.drive_q, req_ready});
      end
      repeat (2) @(negedge clock);
      rsp_start_q.delete();
      rsp_data_q.delete();
      wr_done_cyc_q.delete();
      rst_n = 1'b1;
      repeat (6) @(negedge clock); #1;
      total++;
      if (rsp_start_q.size() != 0 || rsp_data_q.size() != 0 || wr_done_cyc_q.size() != 0) begin
         bad++;
         $display("FAIL rstmid_stale: got rsp_starts=%0d rsp=%0d wr_done=%0d expected 0 0 0",
                  rsp_start_q.size(), rsp_data_q.size(), wr_done_cyc_q.size());
      end
      @(posedge clock); #1;
      send(1'b1, 4'd9, 16'hBEEF, acc);
      do_read(4'd9, 1'b0, d, lat, acc);
      total++;
      if (d !== 16'hBEEF) begin
         bad++;
         $display("FAIL rstmid_readback: got %h expected beef", d);
      end
   endtask

   initial begin
      clock = 1'b0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_backpressure();
      test_alternate();
      test_random();
      test_reset_mid();
      total++;
      if (contention != 0) begin
         bad++;
         $display("FAIL final_contention: got %0d expected 0", contention);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_sram_port_master
